// File: rtl/button_debounce.sv
// button_debounce: synchroniser + counter debounce FSM + press/release/long pulses.
// Ports: clk_i, rst_i (sync, active-high), btn_i (raw pin) -> btn_o, press_o, release_o, long_o.
module button_debounce #(
  parameter int FREQ        = 25,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int DB_CYC   = FREQ * 1000 * DEBOUNCE_MS;
  localparam int LONG_CYC = FREQ * 1000 * LONG_MS;
  localparam int DB_W     = $clog2(DB_CYC + 1);
  localparam int HOLD_W   =
    (LONG_CYC > 0) ? $clog2(LONG_CYC + 1) : 1;

  localparam logic [1:0] S_REL    = 2'd0;
  localparam logic [1:0] S_CAND_P = 2'd1;
  localparam logic [1:0] S_PRS    = 2'd2;
  localparam logic [1:0] S_CAND_R = 2'd3;

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DB_CYC - 1);

  logic            p;
  logic            s1_q, s2_q;
  logic [1:0]      state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_q, btn_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;

  // Polarity is fixed before the synchroniser so the FSM
  // only ever deals with "1 = pressed".
  assign p = btn_i ^ ACTIVE_LOW;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= p;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    btn_d    = btn_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    case (state_q)
      S_REL: begin
        if (s2_q) begin
          state_d  = S_CAND_P;
          db_cnt_d = DB_W'(1);
        end
      end
      S_CAND_P: begin
        if (!s2_q) begin
          state_d  = S_REL;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = S_PRS;
          db_cnt_d = '0;
          btn_d    = 1'b1;
          press_d  = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      S_PRS: begin
        if (!s2_q) begin
          state_d  = S_CAND_R;
          db_cnt_d = DB_W'(1);
        end
      end
      S_CAND_R: begin
        if (s2_q) begin
          state_d  = S_PRS;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = S_REL;
          db_cnt_d = '0;
          btn_d    = 1'b0;
          rel_d    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d  = S_REL;
        db_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_REL;
      db_cnt_q <= '0;
      btn_q    <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      btn_q    <= btn_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign btn_o     = btn_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

  if (LONG_CYC > 0) begin : g_long
    localparam logic [HOLD_W-1:0] H_MAX  =
      HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] H_LAST =
      HOLD_W'(LONG_CYC - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              done_q, done_d;
    logic              long_q, long_d;

    // Hold time keeps running through release bounce
    // (CAND_R) since btn_q stays high until acceptance.
    always_comb begin
      hold_d = hold_q;
      done_d = done_q;
      long_d = 1'b0;
      if (press_d) begin
        hold_d = '0;
        done_d = 1'b0;
      end else if (btn_q) begin
        if (hold_q != H_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
        end
        if (hold_q == H_LAST && !done_q) begin
          long_d = 1'b1;
          done_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hold_q <= '0;
        done_q <= 1'b0;
        long_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        done_q <= done_d;
        long_q <= long_d;
      end
    end

    assign long_o = long_q;
  end else begin : g_nolong
    assign long_o = 1'b0;
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: randomized scenarios against an edge-timestamp model,
// one active-high and one active-low instance sharing clock and reset.
module tb_button_debounce;

  localparam int DB_CYC   = 1000;
  localparam int LONG_CYC = 3000;
  localparam int LAT      = DB_CYC + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic b0  = 1'b0;
  logic b1  = 1'b1;
  logic btn0, pr0, rl0, lg0;
  logic btn1, pr1, rl1, lg1;
  logic [7:0] obs;

  always #5 clk = ~clk;

  button_debounce #(
    .FREQ(1), .DEBOUNCE_MS(1), .LONG_MS(3), .ACTIVE_LOW(1'b0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .btn_i(b0),
    .btn_o(btn0), .press_o(pr0),
    .release_o(rl0), .long_o(lg0)
  );

  button_debounce #(
    .FREQ(1), .DEBOUNCE_MS(1), .LONG_MS(3), .ACTIVE_LOW(1'b1)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .btn_i(b1),
    .btn_o(btn1), .press_o(pr1),
    .release_o(rl1), .long_o(lg1)
  );

  assign obs = {btn0, pr0, rl0, lg0, btn1, pr1, rl1, lg1};

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // Model: level accepted once the value seen by the debouncer
  // (pin delayed by two edges) has been stable DB_CYC edges.
  logic       m_sh1 [2];
  logic       m_sh2 [2];
  logic       m_prev[2];
  logic       m_lvl [2];
  logic       m_done[2];
  int         m_chg [2];
  int         m_pe  [2];
  logic [3:0] m_out [2];

  int mm, mm_cyc, both;
  logic [7:0] mm_got, mm_want;
  int np[2], pa[2], nr[2], ra[2], nl[2], la[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_sh1[k] = 0; m_sh2[k] = 0; m_prev[k] = 0;
      m_lvl[k] = 0; m_done[k] = 1; m_chg[k] = 0;
      m_pe[k] = 0; m_out[k] = 4'h0;
    end
  end

  function automatic logic [7:0] expv();
    return {m_out[0], m_out[1]};
  endfunction

  task automatic model_k(input int k, input logic p,
                         input logic r);
    logic seen, pr, rl, lg;
    if (r) begin
      m_sh1[k] = 0; m_sh2[k] = 0; m_prev[k] = 0;
      m_lvl[k] = 0; m_done[k] = 1;
      m_chg[k] = edge_n; m_out[k] = 4'h0;
    end else begin
      seen = m_sh2[k];
      m_sh2[k] = m_sh1[k];
      m_sh1[k] = p;
      if (seen !== m_prev[k]) begin
        m_prev[k] = seen;
        m_chg[k] = edge_n;
      end
      pr = 0; rl = 0; lg = 0;
      if (m_lvl[k] && !m_done[k] &&
          edge_n == m_pe[k] + LONG_CYC) begin
        lg = 1;
        m_done[k] = 1;
      end
      if (seen != m_lvl[k] &&
          edge_n - m_chg[k] + 1 >= DB_CYC) begin
        m_lvl[k] = seen;
        if (seen) begin
          pr = 1; m_pe[k] = edge_n; m_done[k] = 0;
        end else begin
          rl = 1;
        end
      end
      m_out[k] = {m_lvl[k], pr, rl, lg};
    end
  endtask

  task automatic step(input logic v0, input logic v1,
                      input logic r);
    @(negedge clk);
    b0 = v0; b1 = v1; rst = r;
    @(posedge clk);
    edge_n++;
    model_k(0, v0, r);
    model_k(1, ~v1, r);
    #1;
  endtask

  // Drives one constant segment and gathers pulse statistics
  // plus model disagreements for the caller to judge.
  task automatic seg(input logic v0, input logic v1,
                     input logic r, input int n);
    mm = 0; mm_cyc = -1; both = 0;
    mm_got = '0; mm_want = '0;
    for (int k = 0; k < 2; k++) begin
      np[k] = 0; pa[k] = -1; nr[k] = 0;
      ra[k] = -1; nl[k] = 0; la[k] = -1;
    end
    for (int i = 1; i <= n; i++) begin
      step(v0, v1, r);
      if (obs !== expv()) begin
        if (mm == 0) begin
          mm_cyc = i; mm_got = obs; mm_want = expv();
        end
        mm++;
      end
      if ((pr0 && rl0) || (pr1 && rl1)) both++;
      if (pr0) begin np[0]++; pa[0] = i; end
      if (rl0) begin nr[0]++; ra[0] = i; end
      if (lg0) begin nl[0]++; la[0] = i; end
      if (pr1) begin np[1]++; pa[1] = i; end
      if (rl1) begin nr[1]++; ra[1] = i; end
      if (lg1) begin nl[1]++; la[1] = i; end
    end
  endtask

  task automatic test_reset();
    seg(1'b0, 1'b1, 1'b1, 3);
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL reset_outs got %b want 00000000", obs);
    end
    seg(1'b0, 1'b1, 1'b0, 20);
    total++;
    if (mm !== 0 || np[0] + np[1] !== 0) begin
      bad++;
      $display("FAIL reset_idle mm=%0d presses=%0d want 0/0",
               mm, np[0] + np[1]);
    end
  endtask

  task automatic test_long_press();
    seg(1'b1, 1'b1, 1'b0, 5000);
    total++;
    if (np[0] !== 1 || pa[0] !== LAT) begin
      bad++;
      $display("FAIL lp_press n=%0d at=%0d want 1 at %0d",
               np[0], pa[0], LAT);
    end
    total++;
    if (nl[0] !== 1 || la[0] !== LAT + LONG_CYC) begin
      bad++;
      $display("FAIL lp_long n=%0d at=%0d want 1 at %0d",
               nl[0], la[0], LAT + LONG_CYC);
    end
    total++;
    if (mm !== 0 || btn0 !== 1'b1) begin
      bad++;
      $display("FAIL lp_model mm=%0d cyc=%0d got %b want %b",
               mm, mm_cyc, mm_got, mm_want);
    end
    seg(1'b0, 1'b1, 1'b0, 1100);
    total++;
    if (nr[0] !== 1 || ra[0] !== LAT || nl[0] !== 0) begin
      bad++;
      $display("FAIL lp_release n=%0d at=%0d long=%0d want 1 at %0d",
               nr[0], ra[0], nl[0], LAT);
    end
  endtask

  task automatic test_bounce();
    int bmm = 0;
    int bp = 0;
    for (int i = 0; i < 8; i++) begin
      seg((i % 2) == 0, 1'b1, 1'b0, $urandom_range(50, 150));
      bmm += mm;
      bp += np[0] + nr[0];
    end
    total++;
    if (bp !== 0 || bmm !== 0) begin
      bad++;
      $display("FAIL bounce_quiet pulses=%0d mm=%0d want 0/0",
               bp, bmm);
    end
    seg(1'b1, 1'b1, 1'b0, 1100);
    total++;
    if (np[0] !== 1 || pa[0] !== LAT || mm !== 0) begin
      bad++;
      $display("FAIL bounce_press n=%0d at=%0d mm=%0d want 1 at %0d",
               np[0], pa[0], mm, LAT);
    end
    seg(1'b0, 1'b1, 1'b0, 1100);
    total++;
    if (nr[0] !== 1 || ra[0] !== LAT) begin
      bad++;
      $display("FAIL bounce_release n=%0d at=%0d want 1 at %0d",
               nr[0], ra[0], LAT);
    end
  endtask

  task automatic test_short_press();
    int lsum;
    seg(1'b1, 1'b1, 1'b0, 1500);
    lsum = nl[0];
    total++;
    if (np[0] !== 1 || pa[0] !== LAT || mm !== 0) begin
      bad++;
      $display("FAIL short_press n=%0d at=%0d mm=%0d want 1 at %0d",
               np[0], pa[0], mm, LAT);
    end
    seg(1'b0, 1'b1, 1'b0, 1200);
    lsum += nl[0];
    total++;
    if (nr[0] !== 1 || ra[0] !== LAT || mm !== 0) begin
      bad++;
      $display("FAIL short_release n=%0d at=%0d mm=%0d want 1 at %0d",
               nr[0], ra[0], mm, LAT);
    end
    total++;
    if (lsum !== 0) begin
      bad++;
      $display("FAIL short_long got %0d pulses want 0", lsum);
    end
  endtask

  task automatic test_release_bounce();
    int g;
    seg(1'b1, 1'b1, 1'b0, LAT + 2000);
    total++;
    if (np[0] !== 1 || pa[0] !== LAT) begin
      bad++;
      $display("FAIL rb_press n=%0d at=%0d want 1 at %0d",
               np[0], pa[0], LAT);
    end
    g = $urandom_range(300, 900);
    seg(1'b0, 1'b1, 1'b0, g);
    total++;
    if (nr[0] !== 0 || mm !== 0) begin
      bad++;
      $display("FAIL rb_norel rel=%0d mm=%0d want 0/0",
               nr[0], mm);
    end
    seg(1'b1, 1'b1, 1'b0, 1200 - g);
    total++;
    if (nl[0] !== 1 || la[0] !== 1000 - g || nr[0] !== 0) begin
      bad++;
      $display("FAIL rb_long n=%0d at=%0d want 1 at %0d",
               nl[0], la[0], 1000 - g);
    end
    seg(1'b0, 1'b1, 1'b0, 1100);
    total++;
    if (nr[0] !== 1 || mm !== 0) begin
      bad++;
      $display("FAIL rb_release n=%0d mm=%0d want 1/0",
               nr[0], mm);
    end
  endtask

  task automatic test_reset_mid();
    seg(1'b1, 1'b1, 1'b0, $urandom_range(300, 900));
    total++;
    if (np[0] !== 0) begin
      bad++;
      $display("FAIL rm_early got %0d presses want 0", np[0]);
    end
    seg(1'b1, 1'b1, 1'b1, 1);
    total++;
    if (obs !== 8'h00) begin
      bad++;
      $display("FAIL rm_outs got %b want 00000000", obs);
    end
    seg(1'b1, 1'b1, 1'b0, 1100);
    total++;
    if (np[0] !== 1 || pa[0] !== LAT || mm !== 0) begin
      bad++;
      $display("FAIL rm_press n=%0d at=%0d mm=%0d want 1 at %0d",
               np[0], pa[0], mm, LAT);
    end
    seg(1'b0, 1'b1, 1'b0, 1100);
  endtask

  task automatic test_active_low();
    seg(1'b0, 1'b0, 1'b0, 1200);
    total++;
    if (np[1] !== 1 || pa[1] !== LAT || np[0] !== 0) begin
      bad++;
      $display("FAIL al_press n=%0d at=%0d other=%0d want 1 at %0d",
               np[1], pa[1], np[0], LAT);
    end
    seg(1'b0, 1'b1, 1'b0, 1200);
    total++;
    if (nr[1] !== 1 || ra[1] !== LAT || mm !== 0) begin
      bad++;
      $display("FAIL al_release n=%0d at=%0d mm=%0d want 1 at %0d",
               nr[1], ra[1], mm, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int bmm = 0;
    int bb = 0;
    int sp[2] = '{0, 0};
    int sr[2] = '{0, 0};
    for (int i = 0; i < 24; i++) begin
      seg($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0, $urandom_range(1, 1300));
      bmm += mm; bb += both;
      for (int k = 0; k < 2; k++) begin
        sp[k] += np[k]; sr[k] += nr[k];
      end
    end
    seg(1'b0, 1'b1, 1'b1, 1);
    seg(1'b0, 1'b1, 1'b0, 1100);
    total++;
    if (bmm !== 0) begin
      bad++;
      $display("FAIL b2b_model mm=%0d want 0", bmm);
    end
    total++;
    if (bb !== 0) begin
      bad++;
      $display("FAIL b2b_same_cycle got %0d want 0", bb);
    end
    seg(1'b1, 1'b0, 1'b0, 1100);
    bmm = mm;
    for (int k = 0; k < 2; k++) begin
      sp[k] += np[k]; sr[k] += nr[k];
    end
    seg(1'b0, 1'b1, 1'b0, 1100);
    bmm += mm;
    for (int k = 0; k < 2; k++) begin
      sp[k] += np[k]; sr[k] += nr[k];
    end
    total++;
    if (bmm !== 0 || sr[0] < 1 || sr[1] < 1) begin
      bad++;
      $display("FAIL b2b_pairs mm=%0d rel0=%0d rel1=%0d want 0/>=1/>=1",
               bmm, sr[0], sr[1]);
    end
  endtask

  initial begin
    test_reset();
    test_long_press();
    test_bounce();
    test_short_press();
    test_release_bounce();
    test_reset_mid();
    test_active_low();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
